// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch core.
// Provides the FSM state encoding and the default count constants
// (ticks per second, seconds per minute, minutes per hour, hours before wrap).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_t;

  localparam int DEF_MSEC_COUNT = 1000;
  localparam int DEF_SEC_COUNT  = 60;
  localparam int DEF_MIN_COUNT  = 60;
  localparam int DEF_HOUR_COUNT = 24;

endpackage

// File: rtl/stopwatch_core_mod_counter.sv
// mod_counter: one digit of the stopwatch, counting 0 .. MOD-1.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset, zeroes the count
//   clear  - synchronous clear, zeroes the count
//   inc    - advance by one on this edge
//   count  - registered digit value, $clog2(MOD) bits (MOD must be >= 2)
//   carry  - combinational, high when inc=1 and the digit is at MOD-1;
//            feeds the inc of the next more significant digit
module mod_counter #(
  parameter int MOD = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   inc,
  output logic [$clog2(MOD)-1:0] count,
  output logic                   carry
);

  localparam int W = $clog2(MOD);
  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign carry = inc && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      // Wrap explicitly so a non-power-of-two MOD never shows MOD..2^W-1.
      count <= carry ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: run/pause/clear stopwatch counting hh:mm:ss.mmm.
// Ports:
//   clk, reset  - single clock domain, synchronous active-high reset
//   i_tick      - 1-cycle 1 kHz pulse; counted only while the registered state is RUN
//   i_run_stop  - 1-cycle pulse toggling run/pause (IDLE->RUN, RUN->PAUSE, PAUSE->RUN)
//   i_clear     - 1-cycle pulse; zeroes the time from PAUSE, ignored in RUN
//   o_msec/o_sec/o_min/o_hour - registered digit counts
//   o_running   - registered, high while in RUN
//   o_wrap      - 1-cycle pulse when the full-scale time rolls over to zero
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MSEC_COUNT = DEF_MSEC_COUNT,
  parameter int SEC_COUNT  = DEF_SEC_COUNT,
  parameter int MIN_COUNT  = DEF_MIN_COUNT,
  parameter int HOUR_COUNT = DEF_HOUR_COUNT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_tick,
  input  logic                          i_run_stop,
  input  logic                          i_clear,
  output logic [$clog2(MSEC_COUNT)-1:0] o_msec,
  output logic [$clog2(SEC_COUNT)-1:0]  o_sec,
  output logic [$clog2(MIN_COUNT)-1:0]  o_min,
  output logic [$clog2(HOUR_COUNT)-1:0] o_hour,
  output logic                          o_running,
  output logic                          o_wrap
);

  sw_state_t state_q, state_d;
  logic      running_d;
  logic      count_en;
  logic      clear_cnt;
  logic      carry_msec, carry_sec, carry_min, carry_hour;

  // Counting is gated by the registered state, so a tick alongside
  // RUN->PAUSE is counted while one alongside IDLE/PAUSE->RUN is not.
  assign count_en  = (state_q == ST_RUN) && i_tick;
  assign clear_cnt = (state_q == ST_PAUSE) && i_clear;

  // State register plus registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      o_running <= 1'b0;
      o_wrap    <= 1'b0;
    end else begin
      state_q   <= state_d;
      o_running <= running_d;
      o_wrap    <= carry_hour;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        // A coincident clear holds IDLE rather than starting.
        if (i_run_stop && !i_clear) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_run_stop) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (i_clear)         state_d = ST_IDLE;
        else if (i_run_stop) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic (registered above so o_running tracks state_q exactly)
  always_comb begin
    running_d = (state_d == ST_RUN);
  end

  mod_counter #(.MOD(MSEC_COUNT)) u_msec (
    .clk   (clk),
    .reset (reset),
    .clear (clear_cnt),
    .inc   (count_en),
    .count (o_msec),
    .carry (carry_msec)
  );

  mod_counter #(.MOD(SEC_COUNT)) u_sec (
    .clk   (clk),
    .reset (reset),
    .clear (clear_cnt),
    .inc   (carry_msec),
    .count (o_sec),
    .carry (carry_sec)
  );

  mod_counter #(.MOD(MIN_COUNT)) u_min (
    .clk   (clk),
    .reset (reset),
    .clear (clear_cnt),
    .inc   (carry_sec),
    .count (o_min),
    .carry (carry_min)
  );

  // The hour carry only fires at full scale, which is exactly the wrap event.
  mod_counter #(.MOD(HOUR_COUNT)) u_hour (
    .clk   (clk),
    .reset (reset),
    .clear (clear_cnt),
    .inc   (carry_min),
    .count (o_hour),
    .carry (carry_hour)
  );

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

  // Small configuration used for wrap and randomized checking
  localparam int B_MS = 4;
  localparam int B_S  = 2;
  localparam int B_M  = 2;
  localparam int B_H  = 2;
  localparam int B_FULL = B_MS * B_S * B_M * B_H;

  logic clk;
  int   n_cmp = 0;
  int   n_err = 0;

  // DUT A: default parameters
  logic       rst_a, tick_a, rs_a, clr_a;
  logic [9:0] msec_a;
  logic [5:0] sec_a;
  logic [5:0] min_a;
  logic [4:0] hour_a;
  logic       run_a, wrap_a;

  // DUT B: small parameters
  logic       rst_b, tick_b, rs_b, clr_b;
  logic [1:0] msec_b;
  logic [0:0] sec_b, min_b, hour_b;
  logic       run_b, wrap_b;

  stopwatch_core u_dut_a (
    .clk        (clk),
    .reset      (rst_a),
    .i_tick     (tick_a),
    .i_run_stop (rs_a),
    .i_clear    (clr_a),
    .o_msec     (msec_a),
    .o_sec      (sec_a),
    .o_min      (min_a),
    .o_hour     (hour_a),
    .o_running  (run_a),
    .o_wrap     (wrap_a)
  );

  stopwatch_core #(
    .MSEC_COUNT (B_MS),
    .SEC_COUNT  (B_S),
    .MIN_COUNT  (B_M),
    .HOUR_COUNT (B_H)
  ) u_dut_b (
    .clk        (clk),
    .reset      (rst_b),
    .i_tick     (tick_b),
    .i_run_stop (rs_b),
    .i_clear    (clr_b),
    .o_msec     (msec_b),
    .o_sec      (sec_b),
    .o_min      (min_b),
    .o_hour     (hour_b),
    .o_running  (run_b),
    .o_wrap     (wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Reference model for DUT B: elapsed time as one integer in ms,
  // digits derived by division; stopped-at-zero and paused behave alike.
  int m_total = 0;
  bit m_run   = 1'b0;
  bit m_wrap  = 1'b0;

  function automatic void model_step(bit r, bit t, bit rs, bit cl);
    m_wrap = 1'b0;
    if (r) begin
      m_total = 0;
      m_run   = 1'b0;
    end else if (m_run) begin
      if (t) begin
        m_total = m_total + 1;
        if (m_total == B_FULL) begin
          m_total = 0;
          m_wrap  = 1'b1;
        end
      end
      if (rs) m_run = 1'b0;
    end else begin
      if (cl)      m_total = 0;
      else if (rs) m_run   = 1'b1;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input int ms, input int s, input int mi,
                         input int h, input bit run);
    check({tag, "/msec"}, 32'(msec_a), ms);
    check({tag, "/sec"},  32'(sec_a),  s);
    check({tag, "/min"},  32'(min_a),  mi);
    check({tag, "/hour"}, 32'(hour_a), h);
    check({tag, "/run"},  32'(run_a),  32'(run));
  endtask

  task automatic check_b(input string tag);
    check({tag, "/msec"}, 32'(msec_b), m_total % B_MS);
    check({tag, "/sec"},  32'(sec_b),  (m_total / B_MS) % B_S);
    check({tag, "/min"},  32'(min_b),  (m_total / (B_MS * B_S)) % B_M);
    check({tag, "/hour"}, 32'(hour_b), (m_total / (B_MS * B_S * B_M)) % B_H);
    check({tag, "/run"},  32'(run_b),  32'(m_run));
    check({tag, "/wrap"}, 32'(wrap_b), 32'(m_wrap));
  endtask

  // One clock on DUT A; outputs are sampled 1 time unit after the edge.
  task automatic cyc_a(input bit r, input bit t, input bit rs, input bit cl);
    rst_a = r; tick_a = t; rs_a = rs; clr_a = cl;
    @(posedge clk);
    #1;
    rst_a = 1'b0; tick_a = 1'b0; rs_a = 1'b0; clr_a = 1'b0;
  endtask

  task automatic cyc_b(input bit r, input bit t, input bit rs, input bit cl);
    rst_b = r; tick_b = t; rs_b = rs; clr_b = cl;
    model_step(r, t, rs, cl);
    @(posedge clk);
    #1;
    rst_b = 1'b0; tick_b = 1'b0; rs_b = 1'b0; clr_b = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; tick_a = 1'b0; rs_a = 1'b0; clr_a = 1'b0;
    rst_b = 1'b1; tick_b = 1'b0; rs_b = 1'b0; clr_b = 1'b0;
    @(posedge clk);
    #1;

    // Reset wins over coincident tick and run_stop
    cyc_a(1, 1, 1, 0);
    check_a("reset", 0, 0, 0, 0, 0);
    check("reset/wrap", 32'(wrap_a), 0);

    // run_stop honoured on the first edge after reset; tick there not counted
    cyc_a(0, 1, 1, 0);
    check_a("start", 0, 0, 0, 0, 1);

    // 1000 ticks -> one second
    for (int i = 0; i < 1000; i++) cyc_a(0, 1, 0, 0);
    check_a("1000ticks", 0, 1, 0, 0, 1);

    // Clear is ignored while running
    cyc_a(0, 0, 0, 1);
    check_a("clear_in_run", 0, 1, 0, 0, 1);

    // Tick coinciding with pause is counted, later ticks are not
    for (int i = 0; i < 5; i++) cyc_a(0, 1, 0, 0);
    check_a("msec5", 5, 1, 0, 0, 1);
    cyc_a(0, 1, 1, 0);
    check_a("pause_tick", 6, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc_a(0, 1, 0, 0);
    check_a("paused_hold", 6, 1, 0, 0, 0);

    // Resume: tick on the resume edge is not counted
    cyc_a(0, 1, 1, 0);
    check_a("resume", 6, 1, 0, 0, 1);
    for (int i = 0; i < 2000; i++) cyc_a(0, 1, 0, 0);
    cyc_a(0, 0, 1, 0);
    check_a("pause_sec3", 6, 3, 0, 0, 0);

    // Clear and run_stop together in PAUSE: clear wins
    cyc_a(0, 0, 1, 1);
    check_a("pause_clear_rs", 0, 0, 0, 0, 0);
    cyc_a(0, 1, 0, 0);
    check_a("idle_tick", 0, 0, 0, 0, 0);
    // Both in IDLE: stays IDLE
    cyc_a(0, 0, 1, 1);
    check_a("idle_clear_rs", 0, 0, 0, 0, 0);
    cyc_a(0, 0, 1, 0);
    check_a("idle_start", 0, 0, 0, 0, 1);

    // Reset mid-RUN with a coincident tick
    for (int i = 0; i < 7; i++) cyc_a(0, 1, 0, 0);
    check_a("msec7", 7, 0, 0, 0, 1);
    cyc_a(1, 1, 0, 0);
    check_a("reset_mid_run", 0, 0, 0, 0, 0);
    cyc_a(0, 0, 1, 0);
    check_a("restart", 0, 0, 0, 0, 1);

    // Small configuration: full-scale wrap after 32 ticks
    cyc_b(1, 0, 0, 0);
    check_b("b_reset");
    cyc_b(0, 0, 1, 0);
    check_b("b_start");
    for (int i = 1; i <= 31; i++) begin
      cyc_b(0, 1, 0, 0);
      check("b_prewrap/wrap", 32'(wrap_b), 0);
    end
    check("b_tick31/msec", 32'(msec_b), 3);
    check("b_tick31/sec",  32'(sec_b),  1);
    check("b_tick31/min",  32'(min_b),  1);
    check("b_tick31/hour", 32'(hour_b), 1);
    cyc_b(0, 1, 0, 0);
    check_b("b_tick32");
    check("b_tick32/wrap_const", 32'(wrap_b), 1);
    check("b_tick32/zero", 32'({hour_b, min_b, sec_b, msec_b}), 0);
    cyc_b(0, 0, 0, 0);
    check("b_after_wrap/wrap", 32'(wrap_b), 0);
    check("b_after_wrap/run",  32'(run_b),  1);

    // Randomized commands against the reference model
    for (int i = 0; i < 600; i++) begin
      bit r, t, rs, cl;
      r  = ($urandom_range(0, 99) < 2);
      t  = ($urandom_range(0, 99) < 75);
      rs = ($urandom_range(0, 99) < 8);
      cl = ($urandom_range(0, 99) < 8);
      cyc_b(r, t, rs, cl);
      check_b("b_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
